alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle integer ALU in the EX stage of the RV32I core, directly downstream of the control FSM.
- Consumes alu_en and alu_op from the control unit, plus operand A and operand B from the port A and port B muxes.
- Returns a registered result and a single-cycle alu_valid pulse, which the control unit waits on before leaving EX.
- Shifts are iterative, one bit per cycle; all other ops complete in fixed latency.

Parameters:
- WIDTH, 32, datapath width.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).
- OP_W, 5, alu_op width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_en  input  1  start request; held high by control until it samples alu_valid.
- alu_op  input  OP_W  operation select; sampled at start.
- operand_a  input  WIDTH  port A operand; sampled at start.
- operand_b  input  WIDTH  port B operand; sampled at start.
- result  output  WIDTH  registered result; held until the next start.
- zero  output  1  high when result == 0; registered with result.
- alu_valid  output  1  one-cycle completion pulse.
- illegal_op  output  1  pulses with alu_valid when alu_op is unrecognised.
- busy  output  1  high in EXEC or SHIFT.

Behaviour:
- Reset: state=IDLE; result=0, zero=1, alu_valid=0, illegal_op=0, busy=0; shift counter=0. Reset mid-operation aborts with no alu_valid.
- Op encoding:
  - 00001 ADD
  - 00011 SUB
  - 01010 AND
  - 01100 OR
  - 01101 XOR
  - 01110 SLL
  - 01111 SRL
  - 10000 SRA
  - 11000 ADDR (add, used for load/store address)
  - 00100 SLT (signed)
  - 00101 SLTU
  - Any other value is illegal.
- States: IDLE, EXEC, SHIFT, DONE, HOLD.
- IDLE:
  - alu_en=1 at edge N: latch a, b, op; counter = b[SHAMT_W-1:0]; go to EXEC.
  - alu_en=0: stay.
- EXEC (edge N+1):
  - Non-shift op: result computed combinationally from the latches and registered; go to DONE.
  - Shift op with counter==0: result=a; go to DONE.
  - Shift op with counter!=0: working reg=a; go to SHIFT.
- SHIFT, each edge:
  - SLL: shift left by 1, fill 0.
  - SRL: shift right by 1, fill 0.
  - SRA: shift right by 1, fill with the working reg MSB.
  - Decrement the counter. When the counter reaches 1 on this edge, register the shifted value into result and go to DONE.
- DONE:
  - alu_valid=1 for exactly this one cycle.
  - illegal_op=1 in the same cycle if op was illegal; result=0 in that case.
  - Next edge goes to HOLD.
- HOLD: wait for alu_en=0, then go to IDLE. Control samples alu_valid at the same edge where alu_en is still 1, so the ALU must not restart there.
- Latency, alu_en sample edge to alu_valid high:
  - Non-shift ops: 2 edges.
  - Shifts: 2 + shamt edges; worst case 33 for shamt=31.
- Arithmetic:
  - ADD, SUB and ADDR wrap modulo 2^WIDTH; no overflow flag.
  - SLT and SLTU return {WIDTH-1 zeros, flag}.
  - Only the low SHAMT_W bits of b are used for shifts.
- Abort: alu_en falling to 0 while in EXEC or SHIFT returns to IDLE at the next edge with no alu_valid. result keeps its previous value.
- Operand changes after the start edge are ignored.
- zero updates only when result updates.

Test Plan:
- Reset, then ADD: a=0x7FFFFFFF, b=1, alu_en held -> alu_valid 2 edges after start; result=0x80000000; zero=0; alu_valid low the following cycle; no restart while alu_en stays high through the valid edge.
- SUB: a=5, b=5 -> result=0, zero=1. SLT: a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0.
- SRA: a=0x80000000, b=4 -> alu_valid exactly 6 edges after start; result=0xF8000000. SLL with b=0x20 (shamt 0) -> valid at 2 edges; result=a.
- Illegal op 00010 -> alu_valid and illegal_op pulse together at 2 edges; result=0; control-style handshake completes.
- SLL with b=31; drop alu_en after 3 cycles -> no alu_valid; returns to IDLE; result unchanged. A new ADD then completes normally.
- Assert rst mid-SHIFT -> next edge: IDLE, result=0, zero=1, busy=0, no alu_valid.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU for the EX stage.
// Non-shift ops finish one edge after the start edge. Shifts are iterative,
// one bit per edge. A single-cycle alu_valid pulse signals completion.
// The ALU then waits for alu_en to drop before it accepts a new start.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int OP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_en,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               alu_valid,
    output logic               illegal_op,
    output logic               busy
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5'b01101);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_ADDR = OP_W'(5'b11000);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5'b00101);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_illegal;
    logic               is_shift;
    logic [WIDTH-1:0]   shift_one;

    // Single-edge result from the latched operands; for shifts this is the
    // shamt==0 result (operand A unchanged).
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        is_shift    = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDR: alu_res = a_q + b_q;
            OP_SUB:          alu_res = a_q - b_q;
            OP_AND:          alu_res = a_q & b_q;
            OP_OR:           alu_res = a_q | b_q;
            OP_XOR:          alu_res = a_q ^ b_q;
            OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res  = a_q;
                is_shift = 1'b1;
            end
            default:         alu_illegal = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        shift_one = work_q;
        case (op_q)
            OP_SLL:  shift_one = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_one = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shift_one = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_one = work_q;
        endcase
    end

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (alu_en) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    op_d    = alu_op;
                    cnt_d   = operand_b[SHAMT_W-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!alu_en) begin
                    state_d = S_IDLE;
                end else if (is_shift && (cnt_q != '0)) begin
                    work_d  = a_q;
                    state_d = S_SHIFT;
                end else begin
                    result_d  = alu_res;
                    zero_d    = (alu_res == '0);
                    illegal_d = alu_illegal;
                    state_d   = S_DONE;
                end
            end
            S_SHIFT: begin
                if (!alu_en) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = shift_one;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    // Counter at 1 means this edge performs the final bit shift.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d  = shift_one;
                        zero_d    = (shift_one == '0);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Control still holds alu_en on the edge where it sees alu_valid.
                if (!alu_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result     = result_q;
    assign zero       = zero_q;
    assign alu_valid  = (state_q == S_DONE);
    assign illegal_op = (state_q == S_DONE) && illegal_q;
    assign busy       = (state_q == S_EXEC) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq: vector table plus handshake,
// abort and mid-shift reset sequences.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        alu_en;
    logic [4:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        zero;
    logic        alu_valid;
    logic        illegal_op;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .zero       (zero),
        .alu_valid  (alu_valid),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Full control-style transaction: start, wait for valid, hold alu_en over
    // the valid edge, confirm no restart, then release.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z,
                          input logic exp_ill, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        alu_en    = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            // operands after the start edge must be ignored
            operand_a = $urandom;
            operand_b = $urandom;
            alu_op    = 5'($urandom);
            if (alu_valid) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " zero"}, {31'b0, zero}, {31'b0, exp_z});
        check({name, " illegal_op"}, {31'b0, illegal_op}, {31'b0, exp_ill});
        check({name, " busy at valid"}, {31'b0, busy}, 32'd0);
        $display("op %s a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ill=%0b latency=%0d",
                 name, a, b, result, zero, illegal_op, lat);
        // control samples alu_valid on this edge while alu_en is still high
        @(negedge clk);
        check({name, " valid pulse width"}, {31'b0, alu_valid}, 32'd0);
        check({name, " illegal pulse width"}, {31'b0, illegal_op}, 32'd0);
        @(negedge clk);
        check({name, " no restart"}, {31'b0, busy | alu_valid}, 32'd0);
        alu_en = 1'b0;
        @(negedge clk);
        check({name, " result held"}, result, exp_res);
    endtask

    initial begin : main
        logic [31:0] prev_res;
        int          seen_valid;

        vecs[0]  = '{"ADD",   5'b00001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 2};
        vecs[1]  = '{"SUB",   5'b00011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 2};
        vecs[2]  = '{"SLT",   5'b00100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 2};
        vecs[3]  = '{"SLTU",  5'b00101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2};
        vecs[4]  = '{"SRA4",  5'b10000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 6};
        vecs[5]  = '{"SLL0",  5'b01110, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 2};
        vecs[6]  = '{"ILL",   5'b00010, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b1, 2};
        vecs[7]  = '{"AND",   5'b01010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 2};
        vecs[8]  = '{"OR",    5'b01100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 2};
        vecs[9]  = '{"XOR",   5'b01101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 2};
        vecs[10] = '{"SRL3",  5'b01111, 32'h80000001, 32'h00000003, 32'h10000000, 1'b0, 1'b0, 5};
        vecs[11] = '{"SLL31", 5'b01110, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 33};
        vecs[12] = '{"ADDR",  5'b11000, 32'h00001000, 32'hFFFFFFFC, 32'h00000FFC, 1'b0, 1'b0, 2};
        vecs[13] = '{"SRA1",  5'b10000, 32'h40000000, 32'hFFFFFFE1, 32'h20000000, 1'b0, 1'b0, 3};
        vecs[14] = '{"SLTn",  5'b00100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 2};
        vecs[15] = '{"SUBw",  5'b00011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 2};

        rst       = 1'b1;
        alu_en    = 1'b0;
        alu_op    = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset zero", {31'b0, zero}, 32'd1);
        check("reset alu_valid", {31'b0, alu_valid}, 32'd0);
        check("reset illegal_op", {31'b0, illegal_op}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].z, vecs[i].ill, vecs[i].lat);
        end

        // Abort: SLL by 31, alu_en dropped after 3 cycles.
        prev_res   = result;
        seen_valid = 0;
        @(negedge clk);
        alu_en    = 1'b1;
        alu_op    = 5'b01110;
        operand_a = 32'hA5A5A5A5;
        operand_b = 32'd31;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (alu_valid) seen_valid++;
        end
        check("abort busy before drop", {31'b0, busy}, 32'd1);
        alu_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (alu_valid) seen_valid++;
        end
        check("abort no alu_valid", 32'(seen_valid), 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort result unchanged", result, prev_res);
        $display("op ABORT SLL31 -> result=0x%08h busy=%0b valid_seen=%0d", result, busy, seen_valid);

        run_op("ADD after abort", 5'b00001, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 2);

        // Reset in the middle of a long shift.
        seen_valid = 0;
        @(negedge clk);
        alu_en    = 1'b1;
        alu_op    = 5'b10000;
        operand_a = 32'h80000000;
        operand_b = 32'd20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (alu_valid) seen_valid++;
        end
        check("mid-shift busy", {31'b0, busy}, 32'd1);
        rst    = 1'b1;
        alu_en = 1'b0;
        @(negedge clk);
        check("rst mid-shift result", result, 32'd0);
        check("rst mid-shift zero", {31'b0, zero}, 32'd1);
        check("rst mid-shift busy", {31'b0, busy}, 32'd0);
        if (alu_valid) seen_valid++;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (alu_valid) seen_valid++;
        end
        check("rst mid-shift no alu_valid", 32'(seen_valid), 32'd0);
        $display("op RESET mid-SRA -> result=0x%08h zero=%0b busy=%0b", result, zero, busy);

        run_op("SUB after reset", 5'b00011, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
